gb_stream_src: RTL and testbench
================================

GB_STREAM_SRC -- requirements
Module: gb_stream_src

Interface
REQ-001 Parameter IMG_W, default 8, pixels per line (2..512).
REQ-002 Parameter IMG_H, default 8, lines per frame (1..1023).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port start  input  1  frame request pulse, sampled in IDLE only.
REQ-006 Port seed  input  8  pixel pattern base, captured when start is accepted.
REQ-007 Port arg_1_TDATA  output  8  stream pixel data toward the accelerator input.
REQ-008 Port arg_1_TVALID  output  1  beat valid.
REQ-009 Port arg_1_TREADY  input  1  sink ready.
REQ-010 Port arg_1_TLAST  output  1  high on the final beat of the frame only.
REQ-011 Port busy  output  1  high while a frame is in progress.
REQ-012 Port done  output  1  one-cycle pulse after the last beat handshakes.
REQ-013 Port beat_cnt  output  20  beats handshaken in the current or most recent frame.

Function
REQ-014 FSM states IDLE, SEND, DONE; all outputs driven from registers.
REQ-015 IDLE: start=1 -> capture seed, clear x/y/beat_cnt, go SEND; TVALID=1 from the next cycle (one-cycle latency).
REQ-016 Handshake = TVALID & TREADY in the same cycle; exactly one pixel consumed per handshake.
REQ-017 While TVALID=1 and TREADY=0, TDATA, TLAST and TVALID hold unchanged.
REQ-018 Pixel value = (seed + x + 16*y) mod 256; x = column 0..IMG_W-1, y = row 0..IMG_H-1.
REQ-019 On handshake: x increments; at x=IMG_W-1, x wraps to 0 and y increments.
REQ-020 TLAST=1 only when x=IMG_W-1 and y=IMG_H-1; frame = IMG_W*IMG_H beats.
REQ-021 Handshake on the TLAST beat -> TVALID=0 next cycle, state DONE; done=1 for exactly that one cycle, then IDLE.
REQ-022 beat_cnt increments on every handshake; holds its value in IDLE until the next accepted start.
REQ-023 start while in SEND or DONE is ignored; it is not queued.
REQ-024 busy=1 in SEND and DONE, 0 in IDLE.
REQ-025 TREADY held high throughout -> back-to-back beats, no bubbles (unless REQ-031 applies).
REQ-026 IMG_W*IMG_H must fit in 20 bits; out-of-range parameters are unsupported, with no checking logic.

Reset
REQ-027 rst=1 at a rising edge -> state IDLE, TVALID=0, TLAST=0, TDATA=0, busy=0, done=0, beat_cnt=0, x=y=0.
REQ-028 Reset mid-frame aborts the frame immediately, with no done pulse; dropping TVALID without a handshake is permitted only under reset.
REQ-029 rst has priority over start in the same cycle.

Configuration
REQ-030 Macro GB_STREAM_SRC_GAP_EN selects bubble injection.
REQ-031 With the macro: an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset value 8'hA5) advances every clock in SEND.
- After each handshake, if LFSR bit0=1, TVALID stays 0 for one cycle before the next beat is presented.
- A bubble is never inserted while TVALID=1; there is no bubble after the TLAST beat.
REQ-032 Without the macro: no LFSR logic; behaviour is exactly REQ-025.

Verification
REQ-033 IMG_W=4, IMG_H=2, seed=8'h10, TREADY=1 -> TDATA 10,11,12,13,20,21,22,23 on consecutive cycles; TLAST on the 8th beat only; done one cycle later; beat_cnt=8.
REQ-034 Same config, TREADY low for 3 cycles during beat 3 -> TDATA=12 and TVALID=1 held stable all 3 cycles; sequence unchanged.
REQ-035 seed=8'hFE, IMG_W=4 -> first line FE,FF,00,01, showing mod-256 wrap.
REQ-036 start pulsed again mid-frame -> ignored; exactly 8 beats and one done pulse.
REQ-037 rst asserted after beat 5 -> next cycle TVALID=0, busy=0, beat_cnt=0, no done; a new start replays from seed.
REQ-038 GAP_EN build, default parameters, seed=0 -> 64 beats in order, TVALID never deasserts before a handshake, total cycles > 64.

Source files
------------

// File: rtl/gb_stream_src.sv
// Frame pattern source: streams an IMG_W x IMG_H frame of (seed + x + 16*y) pixels over a valid/ready port.
// Define GB_STREAM_SRC_GAP_EN to insert LFSR-driven bubbles between beats; the default build streams back-to-back.
//
// state | meaning
// IDLE  | waiting for start; beat_cnt keeps last frame's count
// SEND  | presenting pixels, advancing x/y on each handshake
// DONE  | one-cycle done pulse after the TLAST handshake
module gb_stream_src #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  seed,
   output logic [7:0]  arg_1_TDATA,
   output logic        arg_1_TVALID,
   input  logic        arg_1_TREADY,
   output logic        arg_1_TLAST,
   output logic        busy,
   output logic        done,
   output logic [19:0] beat_cnt
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t        state_q;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    seed_q;
   logic [7:0]    tdata_q, tdata_d;
   logic          tvalid_q;
   logic          tlast_q, tlast_d;
   logic          busy_q;
   logic          done_q;
   logic [19:0]   beat_cnt_q;
   logic          hs;
   logic          gap;

   assign hs = tvalid_q & arg_1_TREADY;

   // Next pixel position and value, precomputed so the beat after a handshake is registered.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (x_q == X_LAST) begin
         x_d = '0;
         y_d = y_q + 1'b1;
      end else begin
         x_d = x_q + 1'b1;
      end
      tdata_d = seed_q + 8'(x_d) + 8'({y_d, 4'h0});
      tlast_d = (x_d == X_LAST) && (y_d == Y_LAST);
   end

`ifdef GB_STREAM_SRC_GAP_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 8'hA5;
      end else if (state_q == ST_SEND) begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign gap = lfsr_q[0];
`else
   assign gap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         seed_q     <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  seed_q     <= seed;
                  x_q        <= '0;
                  y_q        <= '0;
                  beat_cnt_q <= '0;
                  tdata_q    <= seed;
                  tlast_q    <= 1'b0;
                  tvalid_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (hs) begin
                  beat_cnt_q <= beat_cnt_q + 20'd1;
                  if (tlast_q) begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= ST_DONE;
                  end else begin
                     x_q      <= x_d;
                     y_q      <= y_d;
                     tdata_q  <= tdata_d;
                     tlast_q  <= tlast_d;
                     tvalid_q <= ~gap;
                  end
               end else if (!tvalid_q) begin
                  // bubble cycle over; the next beat is already loaded
                  tvalid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign arg_1_TDATA  = tdata_q;
   assign arg_1_TVALID = tvalid_q;
   assign arg_1_TLAST  = tlast_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_gb_stream_src.sv
// Bench for gb_stream_src: table of frame scenarios checked through a pixel scoreboard, plus reset sequences.
// Cycle-exact latency/length checks apply only to the default (no GB_STREAM_SRC_GAP_EN) build.
module tb_gb_stream_src;

   localparam int W = 4;
   localparam int H = 2;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  seed;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        busy;
   logic        done;
   logic [19:0] beat_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   gb_stream_src #(.IMG_W(W), .IMG_H(H)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .seed        (seed),
      .arg_1_TDATA (tdata),
      .arg_1_TVALID(tvalid),
      .arg_1_TREADY(tready),
      .arg_1_TLAST (tlast),
      .busy        (busy),
      .done        (done),
      .beat_cnt    (beat_cnt)
   );

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      logic [7:0] seed;
      int         stall_beat;
      int         stall_len;
      bit         restart;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
   } vec_t;

   beat_t sb_q[$];
   vec_t  vecs[5];

   function automatic logic [7:0] model_pix(input logic [7:0] s, input int i);
      return 8'(int'(s) + (i % W) + 16 * (i / W));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input vec_t v);
      int         obs;
      int         hs;
      int         stall_ctr;
      int         last_hs_obs;
      bit         finished;
      logic       prev_stall;
      logic [7:0] prev_data;
      logic       prev_last;
      logic [7:0] first_d;
      logic [7:0] last_d;
      beat_t      exp;
      obs = 0; hs = 0; stall_ctr = 0; last_hs_obs = -1; finished = 0;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; first_d = '0; last_d = '0;
      seed   = v.seed;
      start  = 1'b1;
      tready = 1'b1;
      for (int i = 0; i < N; i++) sb_q.push_back('{model_pix(v.seed, i), (i == N - 1)});
      step;
      start = 1'b0;
      seed  = ~v.seed;
      while (!finished && obs < 100) begin
         if (prev_stall) begin
            chk("hold_valid", 32'(tvalid), 32'd1);
            chk("hold_data", 32'(tdata), 32'(prev_data));
            chk("hold_last", 32'(tlast), 32'(prev_last));
         end
         if (obs == 0) chk("busy_in_send", 32'(busy), 32'd1);
`ifndef GB_STREAM_SRC_GAP_EN
         if (obs == 0) chk("first_valid_latency", 32'(tvalid), 32'd1);
`endif
         if (done) begin
            chk("done_after_last", 32'(obs), 32'(last_hs_obs + 1));
            chk("beat_cnt_at_done", 32'(beat_cnt), 32'(N));
            chk("busy_in_done", 32'(busy), 32'd1);
            finished = 1;
         end
         start  = v.restart && (hs == 3);
         tready = !(tvalid && hs == v.stall_beat && stall_ctr < v.stall_len);
         if (tvalid && !tready) stall_ctr++;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         if (tvalid && tready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp = sb_q.pop_front();
               chk("tdata", 32'(tdata), 32'(exp.data));
               chk("tlast", 32'(tlast), 32'(exp.last));
            end
            if (hs == 0) first_d = tdata;
            last_d      = tdata;
            last_hs_obs = obs;
            hs++;
         end
         obs++;
         step;
      end
      start  = 1'b0;
      tready = 1'b1;
      if (!finished) chk("frame_timeout", 32'd0, 32'd1);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("valid_idle", 32'(tvalid), 32'd0);
      chk("hs_count", 32'(hs), 32'(N));
      chk("first_pixel", 32'(first_d), 32'(v.exp_first));
      chk("last_pixel", 32'(last_d), 32'(v.exp_last));
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
`ifndef GB_STREAM_SRC_GAP_EN
      chk("frame_cycles", 32'(obs - 1), 32'(N + v.stall_len));
`endif
      step;
      chk("beat_cnt_hold_idle", 32'(beat_cnt), 32'(N));
      chk("done_stays_low", 32'(done), 32'd0);
   endtask

   initial begin
      int    hs;
      int    cyc;
      beat_t exp;
      vecs[0] = '{8'h10, 0, 0, 1'b0, 8'h10, 8'h23};
      vecs[1] = '{8'h10, 2, 3, 1'b0, 8'h10, 8'h23};
      vecs[2] = '{8'hFE, 0, 0, 1'b0, 8'hFE, 8'h11};
      vecs[3] = '{8'h10, 0, 0, 1'b1, 8'h10, 8'h23};
      vecs[4] = '{8'h80, 5, 1, 1'b0, 8'h80, 8'h93};

      rst = 1'b1; start = 1'b0; seed = 8'h00; tready = 1'b0;
      step;
      step;
      chk("rst_valid", 32'(tvalid), 32'd0);
      chk("rst_last", 32'(tlast), 32'd0);
      chk("rst_data", 32'(tdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);

      // reset wins over a simultaneous start
      seed = 8'h33; start = 1'b1;
      step;
      rst = 1'b0; start = 1'b0;
      chk("rst_prio_busy", 32'(busy), 32'd0);
      chk("rst_prio_valid", 32'(tvalid), 32'd0);
      step;
      chk("rst_prio_still_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 5; i++) run_frame(vecs[i]);

      // abort mid-frame after five beats
      seed = 8'h10; start = 1'b1; tready = 1'b1;
      for (int i = 0; i < N; i++) sb_q.push_back('{model_pix(8'h10, i), (i == N - 1)});
      step;
      start = 1'b0;
      hs = 0; cyc = 0;
      while (hs < 5 && cyc < 100) begin
         if (tvalid && tready) begin
            exp = sb_q.pop_front();
            chk("abort_tdata", 32'(tdata), 32'(exp.data));
            hs++;
         end
         cyc++;
         step;
      end
      if (hs < 5) chk("abort_timeout", 32'd0, 32'd1);
      chk("beat_cnt_mid", 32'(beat_cnt), 32'd5);
      rst = 1'b1;
      step;
      rst = 1'b0;
      sb_q.delete();
      chk("abort_valid", 32'(tvalid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_beat_cnt", 32'(beat_cnt), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      step;
      chk("abort_no_done", 32'(done), 32'd0);
      run_frame(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
